// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: one request at a time,
// LATENCY wait states, RISC-V sized stores and sign/zero-extended loads.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_go_resp;
  logic          w_we;
  logic [2:0]    w_size;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_size_bad;
  logic          w_misalign;
  logic          w_oor;
  logic          w_err;
  logic [3:0]    w_be;
  logic [31:0]   w_lane_data;
  logic [31:0]   w_word;
  logic [31:0]   w_shift;
  logic [31:0]   w_load;

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign w_accept  = req_valid & req_ready;
  assign w_go_resp = ((r_state == S_WAIT) && (r_cnt == 4'd1)) || (w_accept && (LATENCY == 0));

  // With zero latency the access resolves on the acceptance edge, so use live inputs.
  assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_size  = (r_state == S_IDLE) ? req_size  : r_size;
  assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_off      = w_addr - BASE_ADDR;
  assign w_idx      = w_off[AW+1:2];
  assign w_oor      = (w_off >> (AW + 2)) != 32'd0;
  assign w_misalign = ((w_size[1:0] == 2'b01) && w_addr[0]) ||
                      ((w_size == 3'b010) && (w_addr[1:0] != 2'b00));
  assign w_err      = w_size_bad | w_misalign | w_oor;

  always_comb begin
    w_size_bad = 1'b1;
    case (w_size)
      3'b000, 3'b001, 3'b010: w_size_bad = 1'b0;
      3'b100, 3'b101:         w_size_bad = w_we;
      default:                w_size_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_be        = 4'b0000;
    w_lane_data = w_wdata;
    case (w_size[1:0])
      2'b00: begin
        w_be        = 4'b0001 << w_addr[1:0];
        w_lane_data = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = w_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{w_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_shift;
    case (w_size)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load = {24'd0, w_shift[7:0]};
      3'b101:  w_load = {16'd0, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      if (w_go_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? 32'd0 : w_load;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= 4'(LATENCY);
            r_state <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; a reset in WAIT leaves w_go_resp low so nothing commits.
  always_ff @(posedge clk) begin
    if (w_go_resp && w_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 2, 0 and 4.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  reset, req_valid, req_ready, req_we, resp_valid, resp_err, busy;
  logic [2:0]  req_size   [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [31:0] resp_rdata [3];

  int total = 0;
  int bad   = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_size(req_size[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]), .busy(busy[2]));

  // Issues one request from IDLE (called at posedge+1) and follows it until req_ready returns.
  // lat counts edges from acceptance to the edge that samples resp_valid high.
  task automatic do_req(input int d, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nlow, output int nresp, output logic [31:0] post_rdata);
    rdata = 32'd0; err = 1'b0; lat = 0; nlow = 0; nresp = 0; post_rdata = 32'hFFFF_FFFF;
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
    req_addr[d] = addr; req_wdata[d] = wdata;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_we[d] = ~we; req_size[d] = 3'b010;
    req_addr[d] = ~addr; req_wdata[d] = ~wdata;
    for (int j = 0; j < 24; j++) begin
      if (req_ready[d]) begin
        post_rdata = resp_rdata[d];
        break;
      end
      nlow++;
      if (resp_valid[d]) begin
        nresp++;
        if (lat == 0) begin
          lat = j + 1; rdata = resp_rdata[d]; err = resp_err[d];
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      total++; if (req_ready[d] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 1", d, req_ready[d]); end
      total++; if (resp_valid[d] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", d, resp_valid[d]); end
      total++; if (resp_rdata[d] !== 32'd0) begin bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, resp_rdata[d]); end
      total++; if (resp_err[d] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", d, resp_err[d]); end
      total++; if (busy[d] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, post; logic er; int lat, nl, nr;
    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er, lat, nl, nr, post);
    total++; if (lat !== 3 || nl !== 3 || nr !== 1) begin bad++;
      $display("FAIL sw_timing: lat=%0d low=%0d pulses=%0d want 3/3/1", lat, nl, nr); end
    total++; if (rd !== 32'd0 || er !== 1'b0) begin bad++;
      $display("FAIL sw_resp: rdata=%h err=%b want 0/0", rd, er); end
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, nl, nr, post);
    total++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin bad++;
      $display("FAIL lw_data: rdata=%h err=%b want deadbeef/0", rd, er); end
    total++; if (lat !== 3 || nl !== 3 || nr !== 1) begin bad++;
      $display("FAIL lw_timing: lat=%0d low=%0d pulses=%0d want 3/3/1", lat, nl, nr); end
    total++; if (post !== 32'd0) begin bad++; $display("FAIL rdata_hold: got %h want 0 after pulse", post); end
  endtask

  task automatic test_load_ext();
    logic [31:0] rd, post; logic er; int lat, nl, nr;
    logic [2:0]  sz  [4];
    logic [31:0] ad  [4];
    logic [31:0] exp [4];
    sz[0] = 3'b000; ad[0] = 32'h13; exp[0] = 32'hFFFF_FFDE;
    sz[1] = 3'b100; ad[1] = 32'h13; exp[1] = 32'h0000_00DE;
    sz[2] = 3'b001; ad[2] = 32'h12; exp[2] = 32'hFFFF_DEAD;
    sz[3] = 3'b101; ad[3] = 32'h10; exp[3] = 32'h0000_BEEF;
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b0, sz[i], ad[i], 32'h0, rd, er, lat, nl, nr, post);
      total++; if (rd !== exp[i] || er !== 1'b0) begin bad++;
        $display("FAIL load_ext[%0d]: rdata=%h err=%b want %h/0", i, rd, er, exp[i]); end
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd, post; logic er; int lat, nl, nr;
    do_req(0, 1'b1, 3'b000, 32'h11, 32'h0000_00AA, rd, er, lat, nl, nr, post);
    do_req(0, 1'b1, 3'b001, 32'h12, 32'h0000_1234, rd, er, lat, nl, nr, post);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, nl, nr, post);
    total++; if (rd !== 32'h1234_AAEF || er !== 1'b0) begin bad++;
      $display("FAIL partial_store: rdata=%h err=%b want 1234aaef/0", rd, er); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, post; logic er; int lat, nl, nr;
    logic        we [6];
    logic [2:0]  sz [6];
    logic [31:0] ad [6];
    logic [31:0] wd [6];
    we[0] = 1'b0; sz[0] = 3'b010; ad[0] = 32'h11;   wd[0] = 32'h0;
    we[1] = 1'b1; sz[1] = 3'b001; ad[1] = 32'h13;   wd[1] = 32'h0000_9999;
    we[2] = 1'b0; sz[2] = 3'b011; ad[2] = 32'h10;   wd[2] = 32'h0;
    we[3] = 1'b1; sz[3] = 3'b100; ad[3] = 32'h10;   wd[3] = 32'h0000_0077;
    we[4] = 1'b0; sz[4] = 3'b010; ad[4] = 32'h1000; wd[4] = 32'h0;
    we[5] = 1'b1; sz[5] = 3'b010; ad[5] = 32'h1010; wd[5] = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      do_req(0, we[i], sz[i], ad[i], wd[i], rd, er, lat, nl, nr, post);
      total++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 3) begin bad++;
        $display("FAIL err_case[%0d]: err=%b rdata=%h lat=%0d want 1/0/3", i, er, rd, lat); end
    end
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, nl, nr, post);
    total++; if (rd !== 32'h1234_AAEF || er !== 1'b0) begin bad++;
      $display("FAIL err_no_write: rdata=%h err=%b want 1234aaef/0", rd, er); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, post; logic er; int lat, nl, nr;
    int acc_e [4];
    int resp_e [4];
    logic [31:0] resp_d [4];
    logic [31:0] exp;
    int nacc, nres, npulse;
    logic acc;
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b1, 3'b010, 32'(4 * i), 32'h1111_1111 * 32'(i + 1), rd, er, lat, nl, nr, post);
      acc_e[i] = -1; resp_e[i] = -1; resp_d[i] = 32'd0;
    end
    total++; if (lat !== 1 || nl !== 1) begin bad++;
      $display("FAIL l0_store_timing: lat=%0d low=%0d want 1/1", lat, nl); end
    nacc = 0; nres = 0; npulse = 0;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 3'b010; req_addr[1] = 32'h0;
    for (int e = 0; e < 16; e++) begin
      acc = req_ready[1] & req_valid[1];
      @(posedge clk); #1;
      if (acc && nacc < 4) begin
        acc_e[nacc] = e; nacc++;
        req_addr[1] = 32'(4 * nacc);
        if (nacc == 4) req_valid[1] = 1'b0;
      end
      if (resp_valid[1]) begin
        npulse++;
        if (nres < 4) begin resp_e[nres] = e; resp_d[nres] = resp_rdata[1]; nres++; end
      end
    end
    total++; if (npulse !== 4) begin bad++; $display("FAIL b2b_pulses: got %0d want 4", npulse); end
    for (int i = 0; i < 4; i++) begin
      exp = 32'h1111_1111 * 32'(i + 1);
      total++; if (acc_e[i] !== 2 * i) begin bad++;
        $display("FAIL b2b_accept[%0d]: edge %0d want %0d", i, acc_e[i], 2 * i); end
      total++; if (resp_e[i] !== 2 * i || resp_d[i] !== exp) begin bad++;
        $display("FAIL b2b_resp[%0d]: edge %0d data %h want %0d/%h", i, resp_e[i], resp_d[i], 2 * i, exp); end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, post; logic er; int lat, nl, nr, np;
    do_req(2, 1'b1, 3'b010, 32'h20, 32'hA5A5_A5A5, rd, er, lat, nl, nr, post);
    total++; if (lat !== 5 || nl !== 5) begin bad++;
      $display("FAIL l4_timing: lat=%0d low=%0d want 5/5", lat, nl); end
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_size[2] = 3'b010;
    req_addr[2] = 32'h20; req_wdata[2] = 32'h5555_5555;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL abort_pre_busy: got %b want 1", busy[2]); end
    reset[2] = 1'b1; #1;
    total++; if (busy[2] !== 1'b0 || resp_valid[2] !== 1'b0) begin bad++;
      $display("FAIL abort_reset: busy=%b valid=%b want 0/0", busy[2], resp_valid[2]); end
    @(posedge clk); #1;
    reset[2] = 1'b0; #1;
    total++; if (req_ready[2] !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", req_ready[2]); end
    np = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid[2]) np++;
    end
    total++; if (np !== 0) begin bad++; $display("FAIL abort_pulse: got %0d pulses want 0", np); end
    do_req(2, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, nl, nr, post);
    total++; if (rd !== 32'hA5A5_A5A5) begin bad++; $display("FAIL abort_no_write: got %h want a5a5a5a5", rd); end
    do_req(2, 1'b1, 3'b010, 32'h20, 32'h0, rd, er, lat, nl, nr, post);
    do_req(2, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, nl, nr, post);
    total++; if (rd !== 32'd0 || er !== 1'b0) begin bad++;
      $display("FAIL sw_zero: rdata=%h err=%b want 0/0", rd, er); end
  endtask

  initial begin
    reset = 3'b111; req_valid = 3'b000; req_we = 3'b000;
    for (int d = 0; d < 3; d++) begin
      req_size[d] = 3'b010; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 3'b000;
    #1;
    test_reset();
    @(posedge clk); #1;
    test_store_load();
    test_load_ext();
    test_partial_store();
    test_errors();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RISC-V core's load/store port: the memory end of the core's address/write-data/read-data interface.
- Accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Performs byte, halfword and word stores using funct3 sizing, and returns sign- or zero-extended load data.
- Flags misaligned, out-of-range and illegal-size accesses; this is the target for the core's stall logic.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit storage words; power of two.
- LATENCY, 2: wait-state cycles between acceptance and response; 0 to 15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  3  RISC-V funct3 of the load/store instruction.
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  32  store data, right-aligned (rs2 value).
- resp_valid  output  1  one-cycle pulse; response fields valid.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  access rejected; qualified by resp_valid.
- busy  output  1  request accepted and not yet responded to.

Behaviour:
- Reset:
  - Asynchronous; state goes to IDLE.
  - req_ready=1 after reset release; resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - Storage contents are not reset (undefined).
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Handshake is req_valid&req_ready at a rising edge. On it: capture we/size/addr/wdata, load the counter with LATENCY, and go to WAIT (if LATENCY>0) or RESP (if LATENCY=0).
  - Inputs are ignored when req_valid=0.
- WAIT:
  - req_ready=0, busy=1.
  - Counter decrements each cycle; when it reaches 1, go to RESP on the next edge.
  - Total wait is exactly LATENCY cycles.
- RESP:
  - resp_valid=1 for exactly one cycle; busy=1, req_ready=0. Next state is IDLE.
  - There is no response backpressure.
  - Acceptance-edge to resp_valid-high latency is LATENCY+1 cycles.
  - Back-to-back: the next request can be accepted 1 cycle after RESP, i.e. throughput is one request per LATENCY+2 cycles.
- Output holding: resp_rdata/resp_err are registered, are valid only while resp_valid=1, and are driven to 0 otherwise.
- Error checks, evaluated on captured fields (resp_err=1 if any hold):
  - Size illegal: size not in {000,001,010,100,101}; stores also require size in {000,001,010}.
  - Misaligned: size 001/101 with addr[0]=1; size 010 with addr[1:0]!=00.
  - Out of range: (addr-BASE_ADDR) unsigned >= DEPTH_WORDS*4. This includes addresses below BASE_ADDR, via wrap-around.
- On error: no storage write, resp_rdata=0.
- Store:
  - Committed at the edge entering RESP.
  - Byte enables: SB uses wdata[7:0] at lane addr[1:0]; SH uses wdata[15:0] at lane addr[1]; SW writes all 4 lanes. Other lanes are unchanged.
  - resp_rdata=0.
- Load:
  - Word read at the edge entering RESP, then lane-selected by addr[1:0].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Word index is (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Reset mid-operation:
  - Asserted in WAIT: the request is discarded and no write occurs.
  - Asserted in the RESP cycle: the pulse is cut; the write has already committed.
- req_* changes after acceptance have no effect on the in-flight request.

Test Plan:
- LATENCY=2, SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> store resp_valid 3 cycles after acceptance with rdata=0, err=0; load returns 0xDEADBEEF with req_ready low for 3 cycles each.
- After the word above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x11 wdata 0x000000AA, then SH 0x12 wdata 0x00001234, then LW 0x10 -> 0x1234AAEF.
- LW 0x11, SH 0x13, size=011, SBU-style store with size=100, addr=DEPTH_WORDS*4 -> each gives resp_err=1 and rdata=0; a following LW 0x10 still reads 0x1234AAEF.
- LATENCY=0, req_valid held high with 4 consecutive LW requests -> accepted on alternating edges; resp_valid exactly one cycle after each acceptance.
- LATENCY=4, SW 0x20 wdata 0x55555555, reset pulsed during WAIT -> no resp_valid, and req_ready=1 after release. Then SW 0x20 0x0 followed by LW 0x20 -> 0x00000000, and the aborted store is never observed.
